// File: rtl/link_pkg.sv
// Shared definitions for the minisystem serial link: sync/tag constants,
// receiver state encoding and block classification.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        SYNC1,
        LOCKED
    } link_rx_state_t;

    typedef enum logic [1:0] {
        BLK_PAYLOAD,
        BLK_FILL,
        BLK_BAD
    } link_blk_kind_t;

    localparam logic [31:0] LINK_SYNC_WORD0   = 32'h5555_5555;
    localparam logic [31:0] LINK_SYNC_WORD1   = 32'h5555_5554;
    localparam logic [7:0]  LINK_DATA_TAG     = 8'hA5;
    localparam int unsigned LINK_BLOCK_BITS   = 32;
    localparam int unsigned LINK_PAYLOAD_BITS = 24;
    localparam int unsigned LINK_CNT_BITS     = $clog2(LINK_BLOCK_BITS);

    // The payload tag is tested before the sync words, so a tagged block always wins.
    function automatic link_blk_kind_t link_classify(
        input logic [LINK_BLOCK_BITS-1:0] word,
        input logic [LINK_BLOCK_BITS-1:0] sync0,
        input logic [LINK_BLOCK_BITS-1:0] sync1,
        input logic [7:0]                 tag
    );
        link_blk_kind_t kind;
        if (word[7:0] == tag)
            kind = BLK_PAYLOAD;
        else if ((word == sync0) || (word == sync1))
            kind = BLK_FILL;
        else
            kind = BLK_BAD;
        return kind;
    endfunction

endpackage

// File: rtl/link_rx_deser.sv
// Serial-to-parallel front end: MSB-first shift register plus block bit counter.
// The presented word already includes the bit currently on data_in.
module link_rx_deser
    import link_pkg::*;
(
    input  logic                       clk,
    input  logic                       res,
    input  logic                       data_in,
    input  logic                       cnt_clr,
    output logic [LINK_BLOCK_BITS-1:0] word,
    output logic                       block_done
);

    localparam logic [LINK_CNT_BITS-1:0] CNT_LAST = LINK_CNT_BITS'(LINK_BLOCK_BITS - 1);

    logic [LINK_BLOCK_BITS-1:0] r_shift;
    logic [LINK_CNT_BITS-1:0]   r_cnt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_shift <= {r_shift[LINK_BLOCK_BITS-2:0], data_in};
            if (cnt_clr)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign word       = {r_shift[LINK_BLOCK_BITS-2:0], data_in};
    assign block_done = (r_cnt == CNT_LAST);

endmodule

// File: rtl/link_receiver.sv
// Receive end of the minisystem link: sync acquisition, block classification,
// single-entry payload holding register with overflow and error accounting.
module link_receiver
    import link_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD0 = LINK_SYNC_WORD0,
    parameter logic [31:0] SYNC_WORD1 = LINK_SYNC_WORD1,
    parameter logic [7:0]  DATA_TAG   = LINK_DATA_TAG,
    parameter int unsigned ERR_MAX    = 3
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         cable_connected,
    input  logic                         data_in,
    output logic [LINK_PAYLOAD_BITS-1:0] rx_data,
    output logic                         rx_data_valid,
    input  logic                         rx_data_ready,
    output logic                         link_up,
    output logic                         rx_overflow,
    output logic [7:0]                   rx_err_count
);

    localparam logic [3:0] ERR_LIMIT = 4'(ERR_MAX);

    link_rx_state_t               r_state;
    logic [LINK_PAYLOAD_BITS-1:0] r_data;
    logic                         r_valid;
    logic                         r_link_up;
    logic                         r_overflow;
    logic [7:0]                   r_err_count;
    logic [3:0]                   r_consec;

    logic [LINK_BLOCK_BITS-1:0]   w_word;
    logic                         w_block_done;
    logic                         w_cnt_clr;
    link_blk_kind_t               w_kind;

    // Block alignment is taken from wherever SYNC_WORD0 is found during the search.
    assign w_cnt_clr = cable_connected && (r_state == HUNT) && (w_word == SYNC_WORD0);
    assign w_kind    = link_classify(w_word, SYNC_WORD0, SYNC_WORD1, DATA_TAG);

    link_rx_deser u_deser (
        .clk        (clk),
        .res        (res),
        .data_in    (data_in),
        .cnt_clr    (w_cnt_clr),
        .word       (w_word),
        .block_done (w_block_done)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_link_up   <= 1'b0;
            r_overflow  <= 1'b0;
            r_err_count <= '0;
            r_consec    <= '0;
        end else if (!cable_connected) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_link_up <= 1'b0;
            r_consec  <= '0;
        end else begin
            if (r_valid && rx_data_ready)
                r_valid <= 1'b0;

            case (r_state)
                IDLE: r_state <= HUNT;

                HUNT: begin
                    if (w_word == SYNC_WORD0)
                        r_state <= SYNC1;
                end

                SYNC1: begin
                    if (w_block_done) begin
                        if (w_word == SYNC_WORD1) begin
                            r_state   <= LOCKED;
                            r_link_up <= 1'b1;
                            r_consec  <= '0;
                        end else if (w_word != SYNC_WORD0) begin
                            r_state <= HUNT;
                        end
                    end
                end

                LOCKED: begin
                    if (w_block_done) begin
                        case (w_kind)
                            BLK_PAYLOAD: begin
                                r_consec <= '0;
                                // A same-edge accept frees the slot for the new payload.
                                if (!r_valid || rx_data_ready) begin
                                    r_data  <= w_word[LINK_BLOCK_BITS-1 -: LINK_PAYLOAD_BITS];
                                    r_valid <= 1'b1;
                                end else begin
                                    r_overflow <= 1'b1;
                                end
                            end
                            BLK_FILL: r_consec <= '0;
                            default: begin
                                if (r_err_count != 8'hFF)
                                    r_err_count <= r_err_count + 8'd1;
                                if ((r_consec + 4'd1) >= ERR_LIMIT) begin
                                    r_state   <= HUNT;
                                    r_link_up <= 1'b0;
                                    r_consec  <= '0;
                                end else begin
                                    r_consec <= r_consec + 4'd1;
                                end
                            end
                        endcase
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_data       = r_data;
    assign rx_data_valid = r_valid;
    assign link_up       = r_link_up;
    assign rx_overflow   = r_overflow;
    assign rx_err_count  = r_err_count;

endmodule

// File: tb/tb_link_receiver.sv
// Directed and randomized checks of link_receiver against a block-level
// reference model of the holding register and error counters.
module tb_link_receiver;

    localparam logic [31:0] SW0 = 32'h5555_5555;
    localparam logic [31:0] SW1 = 32'h5555_5554;
    localparam int unsigned ERRMAX = 3;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        cable_connected = 1'b0;
    logic        data_in = 1'b0;
    logic [23:0] rx_data;
    logic        rx_data_valid;
    logic        rx_data_ready = 1'b0;
    logic        link_up;
    logic        rx_overflow;
    logic [7:0]  rx_err_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic mon_en = 1'b0;
    logic saw_up = 1'b0;

    link_receiver #(
        .SYNC_WORD0 (SW0),
        .SYNC_WORD1 (SW1),
        .DATA_TAG   (8'hA5),
        .ERR_MAX    (ERRMAX)
    ) dut (
        .clk             (clk),
        .res             (res),
        .cable_connected (cable_connected),
        .data_in         (data_in),
        .rx_data         (rx_data),
        .rx_data_valid   (rx_data_valid),
        .rx_data_ready   (rx_data_ready),
        .link_up         (link_up),
        .rx_overflow     (rx_overflow),
        .rx_err_count    (rx_err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mon_en && link_up) saw_up <= 1'b1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input logic [31:0] w, input int unsigned hi, input int unsigned lo);
        for (int i = int'(hi); i >= int'(lo); i--) send_bit(w[i]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_range(w, 31, 0);
    endtask

    // Prefix of zeros ends in 0, so SYNC_WORD0 cannot be matched early.
    task automatic relock();
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        send_word(SW0);
        send_word(SW1);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] r;
        logic [6:0]  pre;
        int unsigned kind;
        logic        m_valid, m_ovf, rdy;
        logic [23:0] m_data;
        int unsigned m_err, m_consec;

        // Reset state
        #2;
        check("rst_link_up", 32'(link_up), 0);
        check("rst_valid", 32'(rx_data_valid), 0);
        check("rst_data", 32'(rx_data), 0);
        check("rst_ovf", 32'(rx_overflow), 0);
        check("rst_err", 32'(rx_err_count), 0);
        #10 res = 1'b0;
        @(posedge clk); #1;

        // Lock after random lead-in; final lead-in bit held at 0 to avoid early match
        cable_connected = 1'b1;
        rx_data_ready   = 1'b1;
        pre = 7'($urandom);
        pre[0] = 1'b0;
        for (int i = 6; i >= 0; i--) send_bit(pre[i]);
        send_word(SW0);
        check("lock_after_sw0", 32'(link_up), 0);
        send_range(SW1, 31, 1);
        check("lock_before_lsb", 32'(link_up), 0);
        send_range(SW1, 0, 0);
        check("lock_at_lsb", 32'(link_up), 1);
        check("lock_valid", 32'(rx_data_valid), 0);

        // Payload with ready held high
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: w = 32'h0000_01A5;
                1: w = 32'h0000_02A5;
                default: w = 32'h1234_56A5;
            endcase
            send_range(w, 31, 31);
            check("pl_valid_drop", 32'(rx_data_valid), 0);
            send_range(w, 30, 1);
            check("pl_valid_early", 32'(rx_data_valid), 0);
            send_range(w, 0, 0);
            check("pl_valid", 32'(rx_data_valid), 1);
            check("pl_data", 32'(rx_data), {8'h00, w[31:8]});
        end
        send_range(SW0, 31, 31);
        check("pl_pulse_end", 32'(rx_data_valid), 0);
        send_range(SW0, 30, 0);
        check("pl_ovf", 32'(rx_overflow), 0);

        // Backpressure
        rx_data_ready = 1'b0;
        send_word(32'hABCD_EFA5);
        check("bp_valid", 32'(rx_data_valid), 1);
        check("bp_data", 32'(rx_data), 32'h00AB_CDEF);
        check("bp_ovf_before", 32'(rx_overflow), 0);
        send_word(32'h1111_11A5);
        check("bp_held_data", 32'(rx_data), 32'h00AB_CDEF);
        check("bp_held_valid", 32'(rx_data_valid), 1);
        check("bp_ovf", 32'(rx_overflow), 1);
        rx_data_ready = 1'b1;
        send_range(SW0, 31, 31);
        check("bp_accept", 32'(rx_data_valid), 0);
        send_range(SW0, 30, 0);

        // Fill and errors
        check("fill_valid", 32'(rx_data_valid), 0);
        check("fill_locked", 32'(link_up), 1);
        send_word(32'h0000_0003);
        check("err_1", 32'(rx_err_count), 1);
        send_word(32'h0000_0003);
        check("err_2", 32'(rx_err_count), 2);
        check("err_2_locked", 32'(link_up), 1);
        send_word(32'h0000_10A5);
        check("err_pl_data", 32'(rx_data), 32'h0000_0010);
        send_word(32'h0000_0003);
        send_word(32'h0000_0003);
        check("err_4_locked", 32'(link_up), 1);
        send_range(32'h0000_0003, 31, 1);
        check("err_5_before_lsb", 32'(link_up), 1);
        send_range(32'h0000_0003, 0, 0);
        check("err_5_unlock", 32'(link_up), 0);
        check("err_5_count", 32'(rx_err_count), 5);

        // Disconnect mid-block
        rx_data_ready = 1'b0;
        relock();
        check("dc_relock", 32'(link_up), 1);
        send_word(32'h0BEE_F0A5);
        check("dc_valid", 32'(rx_data_valid), 1);
        send_range(SW0, 31, 22);
        cable_connected = 1'b0;
        send_bit(1'b0);
        check("dc_link_up", 32'(link_up), 0);
        check("dc_valid_clr", 32'(rx_data_valid), 0);
        check("dc_err_kept", 32'(rx_err_count), 5);
        check("dc_ovf_kept", 32'(rx_overflow), 1);

        // Asynchronous reset pulse between edges
        #1 res = 1'b1;
        #1;
        check("ares_link_up", 32'(link_up), 0);
        check("ares_valid", 32'(rx_data_valid), 0);
        check("ares_data", 32'(rx_data), 0);
        check("ares_ovf", 32'(rx_overflow), 0);
        check("ares_err", 32'(rx_err_count), 0);
        #2 res = 1'b0;
        @(posedge clk); #1;

        // False-sync rejection, then re-sync
        cable_connected = 1'b1;
        rx_data_ready   = 1'b1;
        saw_up = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        send_word(SW0);
        send_word(32'h1234_5678);
        check("fs_not_locked", 32'(link_up), 0);
        send_word(SW0);
        send_word(SW0);
        check("fs_sw0_sw0", 32'(link_up), 0);
        mon_en = 1'b0;
        check("fs_never_up", 32'(saw_up), 0);
        send_word(SW1);
        check("fs_resync", 32'(link_up), 1);

        // Randomized block stream against the reference model
        m_valid = 1'b0; m_ovf = 1'b0; m_data = '0; m_err = 0; m_consec = 0;
        for (int b = 0; b < 24; b++) begin
            kind = $urandom_range(0, 2);
            if (kind == 2 && m_consec == ERRMAX - 1) kind = 0;
            rdy = 1'($urandom_range(0, 1));
            rx_data_ready = rdy;
            r = $urandom;
            if (kind == 0) begin
                w = {r[23:0], 8'hA5};
            end else if (kind == 1) begin
                w = r[0] ? SW1 : SW0;
            end else begin
                w = r;
                if (w[7:0] == 8'hA5) w[7:0] = 8'h00;
                if (w == SW0 || w == SW1) w[31] = 1'b1;
            end
            send_word(w);
            if (m_valid && rdy) m_valid = 1'b0;
            if (kind == 0) begin
                m_consec = 0;
                if (m_valid) m_ovf = 1'b1;
                else begin m_valid = 1'b1; m_data = w[31:8]; end
            end else if (kind == 1) begin
                m_consec = 0;
            end else begin
                m_consec++;
                if (m_err < 255) m_err++;
            end
            check("rnd_valid", 32'(rx_data_valid), 32'(m_valid));
            if (m_valid) check("rnd_data", 32'(rx_data), 32'(m_data));
            check("rnd_ovf", 32'(rx_overflow), 32'(m_ovf));
            check("rnd_err", 32'(rx_err_count), m_err);
            check("rnd_link_up", 32'(link_up), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
